// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg
//   Shared definitions for the neural-network layer streaming blocks:
//   default frame geometry, the serializer state encoding and a helper
//   that sizes index counters.
package nn_stream_pkg;

  localparam int NN_NUM_NEURONS = 30;
  localparam int NN_DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } ser_state_t;

  // Bits needed to index n items (at least one bit so that vectors stay legal).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_stream_serializer_frame_buffer.sv
// frame_buffer
//   Two-slot frame store for the layer serializer: an "active" slot that is
//   being streamed out and a "pending" slot that holds the next frame.
//   Ports:
//     clk, rst      rising-edge clock, synchronous active-high reset
//     load_active   write din into the active slot
//     load_pending  write din into the pending slot
//     swap          copy pending into active (may coincide with load_pending,
//                   in which case pending takes the new din)
//     din           parallel frame, element k at [k*dataWidth +: dataWidth]
//     rd_pending    read port slot select (1 = pending, 0 = active)
//     rd_idx        read port element index
//     rd_data       combinational read data
module frame_buffer
  import nn_stream_pkg::*;
#(
  parameter int numNeurons = NN_NUM_NEURONS,
  parameter int dataWidth  = NN_DATA_WIDTH,
  localparam int IDXW      = idx_width(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_active,
  input  logic                            load_pending,
  input  logic                            swap,
  input  logic [numNeurons*dataWidth-1:0] din,
  input  logic                            rd_pending,
  input  logic [IDXW-1:0]                 rd_idx,
  output logic [dataWidth-1:0]            rd_data
);

  logic [dataWidth-1:0] active_r  [numNeurons];
  logic [dataWidth-1:0] pending_r [numNeurons];

  // Slot storage: load or swap; elements are stored untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < numNeurons; k++) begin
        active_r[k]  <= {dataWidth{1'b0}};
        pending_r[k] <= {dataWidth{1'b0}};
      end
    end else begin
      for (int k = 0; k < numNeurons; k++) begin
        if (load_active) begin
          active_r[k] <= din[k*dataWidth +: dataWidth];
        end else if (swap) begin
          active_r[k] <= pending_r[k];
        end
        if (load_pending) begin
          pending_r[k] <= din[k*dataWidth +: dataWidth];
        end
      end
    end
  end

  // Indexed read from the selected slot.
  always_comb begin
    rd_data = {dataWidth{1'b0}};
    if (rd_pending) begin
      rd_data = pending_r[rd_idx];
    end else begin
      rd_data = active_r[rd_idx];
    end
  end

endmodule

// File: rtl/layer_stream_serializer.sv
// layer_stream_serializer
//   Turns a parallel layer output frame into a stream of numNeurons elements
//   (one per cycle) for the next layer, with at least gapCycles idle cycles
//   between frames. One extra frame can wait in a pending slot; a frame that
//   arrives while that slot is occupied is dropped and flags overrun.
//   Optional feature: define SER_LAST_EN to add out_last, which marks the
//   final element of each frame.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     x_in       parallel frame, element k at [k*dataWidth +: dataWidth]
//     x_valid    single-cycle frame strobe
//     out_data   serialized element (holds while out_valid is low)
//     out_valid  element strobe
//     busy       not idle, or a frame is waiting in the pending slot
//     overrun    sticky: a frame was dropped
//     out_last   (SER_LAST_EN only) last element of the frame
//   gapCycles must be at least 1 and numNeurons at least 2.
module layer_stream_serializer
  import nn_stream_pkg::*;
#(
  parameter int numNeurons = NN_NUM_NEURONS,
  parameter int dataWidth  = NN_DATA_WIDTH,
  parameter int gapCycles  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] x_in,
  input  logic                            x_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            overrun
`ifdef SER_LAST_EN
  ,
  output logic                            out_last
`endif
);

  localparam int IDXW = idx_width(numNeurons);
  localparam int GAPW = idx_width(gapCycles);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(numNeurons - 1);
  localparam logic [GAPW-1:0] GAP_LAST = GAPW'(gapCycles - 1);

  ser_state_t           state_r, state_nxt_s;
  logic [IDXW-1:0]      idx_r, idx_nxt_s, rd_idx_s;
  logic [GAPW-1:0]      gap_cnt_r, gap_cnt_nxt_s;
  logic                 pend_full_r, pend_full_nxt_s;
  logic                 last_elem_s, gap_done_s;
  logic                 start_new_s, start_pend_s, load_pend_s, drop_s;
  logic [dataWidth-1:0] rd_data_s, out_data_nxt_s;
  logic                 out_valid_nxt_s, busy_nxt_s, overrun_nxt_s;
`ifdef SER_LAST_EN
  logic                 out_last_nxt_s;
`endif

  // idx_r is the element currently on out_data while streaming.
  assign last_elem_s = (idx_r == LAST_IDX);
  assign gap_done_s  = (gap_cnt_r == GAP_LAST);

  frame_buffer #(
    .numNeurons (numNeurons),
    .dataWidth  (dataWidth)
  ) u_frame_buffer (
    .clk          (clk),
    .rst          (rst),
    .load_active  (start_new_s),
    .load_pending (load_pend_s),
    .swap         (start_pend_s),
    .din          (x_in),
    .rd_pending   (start_pend_s),
    .rd_idx       (rd_idx_s),
    .rd_data      (rd_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. A frame left in pending while idle (it arrived in the
  // last gap cycle) is started from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pend_full_r || x_valid) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_elem_s) begin
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_STREAM;
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          state_nxt_s = pend_full_r ? ST_STREAM : ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath control and next values of the registered outputs. Outputs are
  // computed one cycle ahead so the first element appears the cycle after
  // the strobe; a new frame's element 0 bypasses the buffer.
  always_comb begin
    start_new_s  = (state_r == ST_IDLE) && !pend_full_r && x_valid;
    start_pend_s = pend_full_r &&
                   ((state_r == ST_IDLE) || ((state_r == ST_GAP) && gap_done_s));
    // The pending slot accepts a frame when empty or being drained this cycle.
    load_pend_s  = x_valid && !start_new_s && (!pend_full_r || start_pend_s);
    drop_s       = x_valid && pend_full_r && !start_pend_s;

    if (load_pend_s) begin
      pend_full_nxt_s = 1'b1;
    end else if (start_pend_s) begin
      pend_full_nxt_s = 1'b0;
    end else begin
      pend_full_nxt_s = pend_full_r;
    end

    if (start_pend_s || last_elem_s) begin
      rd_idx_s = {IDXW{1'b0}};
    end else begin
      rd_idx_s = idx_r + IDXW'(1);
    end

    if (start_new_s || start_pend_s) begin
      idx_nxt_s = {IDXW{1'b0}};
    end else if ((state_r == ST_STREAM) && !last_elem_s) begin
      idx_nxt_s = idx_r + IDXW'(1);
    end else begin
      idx_nxt_s = idx_r;
    end

    if ((state_r == ST_STREAM) && last_elem_s) begin
      gap_cnt_nxt_s = {GAPW{1'b0}};
    end else if ((state_r == ST_GAP) && !gap_done_s) begin
      gap_cnt_nxt_s = gap_cnt_r + GAPW'(1);
    end else begin
      gap_cnt_nxt_s = gap_cnt_r;
    end

    if (start_new_s) begin
      out_data_nxt_s = x_in[dataWidth-1:0];
    end else if (start_pend_s || ((state_r == ST_STREAM) && !last_elem_s)) begin
      out_data_nxt_s = rd_data_s;
    end else begin
      out_data_nxt_s = out_data;
    end

    out_valid_nxt_s = (state_nxt_s == ST_STREAM);
    busy_nxt_s      = (state_nxt_s != ST_IDLE) || pend_full_nxt_s;
    overrun_nxt_s   = overrun || drop_s;
`ifdef SER_LAST_EN
    out_last_nxt_s  = (state_nxt_s == ST_STREAM) && (idx_nxt_s == LAST_IDX);
`endif
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r       <= {IDXW{1'b0}};
      gap_cnt_r   <= {GAPW{1'b0}};
      pend_full_r <= 1'b0;
      out_data    <= {dataWidth{1'b0}};
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
`ifdef SER_LAST_EN
      out_last    <= 1'b0;
`endif
    end else begin
      idx_r       <= idx_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
      pend_full_r <= pend_full_nxt_s;
      out_data    <= out_data_nxt_s;
      out_valid   <= out_valid_nxt_s;
      busy        <= busy_nxt_s;
      overrun     <= overrun_nxt_s;
`ifdef SER_LAST_EN
      out_last    <= out_last_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_layer_stream_serializer.sv
// tb_layer_stream_serializer
//   Self-checking bench for layer_stream_serializer (numNeurons=4,
//   dataWidth=16, gapCycles=2): a per-cycle vector table, hand-written
//   corner sequences, then random traffic against a queue-based model.
module tb_layer_stream_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 2;
  localparam int FW = N * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] x_in = '0;
  logic          x_valid = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          overrun;
`ifdef SER_LAST_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  layer_stream_serializer #(
    .numNeurons (N),
    .dataWidth  (DW),
    .gapCycles  (G)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // A frame becomes a queue of elements; after its last element the engine
  // owes G quiet cycles; one further frame may wait in m_pend.
  logic [DW-1:0] m_rem[$];
  logic [FW-1:0] m_pend[$];
  bit            m_valid, m_ov, m_busy, m_last;
  logic [DW-1:0] m_data;
  int            m_gap;

  task automatic m_start(input logic [FW-1:0] f);
    m_rem.delete();
    for (int k = 1; k < N; k++) m_rem.push_back(f[k*DW +: DW]);
    m_data  = f[DW-1:0];
    m_valid = 1'b1;
  endtask

  task automatic model_step(input bit r, input bit v, input logic [FW-1:0] x);
    bit consumed;
    consumed = 1'b0;
    if (r) begin
      m_rem.delete(); m_pend.delete();
      m_valid = 0; m_ov = 0; m_busy = 0; m_last = 0; m_gap = 0; m_data = '0;
    end else begin
      if (m_valid) begin
        if (m_rem.size() > 0) m_data = m_rem.pop_front();
        else begin m_valid = 0; m_gap = G; end
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0 && m_pend.size() > 0) m_start(m_pend.pop_front());
      end else if (m_pend.size() > 0) begin
        m_start(m_pend.pop_front());
      end else if (v) begin
        m_start(x);
        consumed = 1'b1;
      end
      if (v && !consumed) begin
        if (m_pend.size() == 0) m_pend.push_back(x);
        else m_ov = 1'b1;
      end
      m_last = m_valid && (m_rem.size() == 0);
      m_busy = m_valid || (m_gap > 0) || (m_pend.size() > 0);
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic r, input logic v, input logic [FW-1:0] x);
    rst = r; x_valid = v; x_in = x;
    model_step(r, v, x);
    @(posedge clk); #1;
    rst = 1'b0; x_valid = 1'b0;
  endtask

  logic [DW-1:0] got[$];

  task automatic step_rec(input logic r, input logic v, input logic [FW-1:0] x);
    cyc(r, v, x);
    if (out_valid === 1'b1) got.push_back(out_data);
  endtask

  task automatic check_stream(input string name, input logic [FW-1:0] fa,
                              input logic [FW-1:0] fb, input logic [FW-1:0] fc, input int nf);
    logic [FW-1:0] fr[3];
    fr[0] = fa; fr[1] = fb; fr[2] = fc;
    check({name, "_count"}, got.size(), nf * N);
    for (int k = 0; k < nf * N; k++)
      check(name, (k < got.size()) ? {16'h0, got[k]} : 32'hdead_beef,
            {16'h0, fr[k/N][(k%N)*DW +: DW]});
  endtask

  typedef struct packed {
    logic          xv;
    logic [FW-1:0] x;
    logic          ev;
    logic [DW-1:0] ed;
    logic          eb;
    logic          eo;
    logic          el;
  } vec_t;

  function automatic vec_t mk(input logic xv, input logic [FW-1:0] x, input logic ev,
                              input logic [DW-1:0] ed, input logic eb, input logic el);
    vec_t r;
    r.xv = xv; r.x = x; r.ev = ev; r.ed = ed; r.eb = eb; r.eo = 1'b0; r.el = el;
    return r;
  endfunction

  initial begin
    logic [FW-1:0] fa, fb, fc, z, rx;
    vec_t tbl[21];
    int pct;
    bit rr, rv;

    fa = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    fb = {16'h0b04, 16'h0b03, 16'h0b02, 16'h0b01};
    fc = {16'h0c04, 16'h0c03, 16'h0c02, 16'h0c01};
    z  = '0;

    // Row = inputs for one cycle and the outputs expected in the next.
    // Rows 0..7: single frame; rows 8..20: second frame arriving mid-stream.
    tbl[0]  = mk(1, fa, 1, 16'h0001, 1, 0);
    tbl[1]  = mk(0, z,  1, 16'h0002, 1, 0);
    tbl[2]  = mk(0, z,  1, 16'h0003, 1, 0);
    tbl[3]  = mk(0, z,  1, 16'h0004, 1, 1);
    tbl[4]  = mk(0, z,  0, 16'h0004, 1, 0);
    tbl[5]  = mk(0, z,  0, 16'h0004, 1, 0);
    tbl[6]  = mk(0, z,  0, 16'h0004, 0, 0);
    tbl[7]  = mk(0, z,  0, 16'h0004, 0, 0);
    tbl[8]  = mk(1, fb, 1, 16'h0b01, 1, 0);
    tbl[9]  = mk(0, z,  1, 16'h0b02, 1, 0);
    tbl[10] = mk(1, fc, 1, 16'h0b03, 1, 0);
    tbl[11] = mk(0, z,  1, 16'h0b04, 1, 1);
    tbl[12] = mk(0, z,  0, 16'h0b04, 1, 0);
    tbl[13] = mk(0, z,  0, 16'h0b04, 1, 0);
    tbl[14] = mk(0, z,  1, 16'h0c01, 1, 0);
    tbl[15] = mk(0, z,  1, 16'h0c02, 1, 0);
    tbl[16] = mk(0, z,  1, 16'h0c03, 1, 0);
    tbl[17] = mk(0, z,  1, 16'h0c04, 1, 1);
    tbl[18] = mk(0, z,  0, 16'h0c04, 1, 0);
    tbl[19] = mk(0, z,  0, 16'h0c04, 1, 0);
    tbl[20] = mk(0, z,  0, 16'h0c04, 0, 0);

    // Reset with a coincident frame strobe: strobe must be ignored.
    cyc(1, 1, fa);
    cyc(1, 1, fa);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
`ifdef SER_LAST_EN
    check("rst_last", out_last, 0);
`endif
    cyc(0, 0, z);
    check("rst_strobe_ignored_valid", out_valid, 0);
    check("rst_strobe_ignored_busy", busy, 0);

    // Vector table.
    for (int i = 0; i < 21; i++) begin
      cyc(0, tbl[i].xv, tbl[i].x);
      check($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
      check($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      check($sformatf("tbl%0d_overrun", i), overrun, tbl[i].eo);
`ifdef SER_LAST_EN
      check($sformatf("tbl%0d_last", i), out_last, tbl[i].el);
`endif
    end

    // Frames at t0, t2, t3: third dropped, overrun from t4 and held.
    cyc(1, 0, z); got.delete();
    step_rec(0, 1, fa);
    step_rec(0, 0, z);
    step_rec(0, 1, fb);
    check("ovr_t3", overrun, 0);
    step_rec(0, 1, fc);
    check("ovr_t4", overrun, 1);
    repeat (12) step_rec(0, 0, z);
    check("ovr_held", overrun, 1);
    check("ovr_busy_end", busy, 0);
    check_stream("drop_stream", fa, fb, z, 2);

    // New frame on the pending->active transfer edge: accepted.
    cyc(1, 0, z); got.delete();
    step_rec(0, 1, fa);
    step_rec(0, 0, z);
    step_rec(0, 1, fb);
    repeat (3) step_rec(0, 0, z);
    step_rec(0, 1, fc);
    repeat (14) step_rec(0, 0, z);
    check("xfer_overrun", overrun, 0);
    check_stream("xfer_stream", fa, fb, fc, 3);

    // Reset mid-stream aborts; next frame restarts at element 0.
    cyc(1, 0, z);
    cyc(0, 1, fa);
    cyc(0, 0, z);
    cyc(1, 0, z);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data", out_data, 0);
    cyc(0, 0, z);
    cyc(0, 0, z);
    check("abort_idle", out_valid, 0);
    cyc(0, 1, fb);
    for (int k = 0; k < N; k++) begin
      check($sformatf("restart_valid%0d", k), out_valid, 1);
      check($sformatf("restart_data%0d", k), out_data, fb[k*DW +: DW]);
      cyc(0, 0, z);
    end
    check("restart_gap", out_valid, 0);

    // Random traffic against the model, with varying frame density.
    cyc(1, 0, z);
    for (int i = 0; i < 3000; i++) begin
      case ((i / 250) % 4)
        0: pct = 10;
        1: pct = 30;
        2: pct = 60;
        default: pct = 90;
      endcase
      rr = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 99) < pct);
      rx = {$urandom, $urandom};
      cyc(rr, rv, rx);
      check("rnd_valid", out_valid, m_valid);
      check("rnd_data", out_data, m_data);
      check("rnd_busy", busy, m_busy);
      check("rnd_overrun", overrun, m_ov);
`ifdef SER_LAST_EN
      check("rnd_last", out_last, m_last);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_stream_serializer.md
LAYER_STREAM_SERIALIZER -- requirements
Module: layer_stream_serializer

Interface
REQ-001 The block SHALL have parameter numNeurons, default 30, the number of parallel neuron outputs per frame.
REQ-002 The block SHALL have parameter dataWidth, default 16, the width of each element.
REQ-003 The block SHALL have parameter gapCycles, default 2, the minimum number of idle cycles between output frames.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 x_in  input  numNeurons*dataWidth  parallel frame; element k is bits [k*dataWidth +: dataWidth].
REQ-007 x_valid  input  1  single-cycle frame strobe, driven from the layer's neuron outvalid.
REQ-008 out_data  output  dataWidth  serialized element, feeding the next layer's myinput.
REQ-009 out_valid  output  1  element strobe, feeding the next layer's myinputValid.
REQ-010 busy  output  1  high whenever state is not IDLE or the pending slot is full.
REQ-011 overrun  output  1  sticky flag: a frame was dropped.

Function
REQ-012 States SHALL be IDLE, STREAM and GAP; all outputs SHALL be registered.
REQ-013 IDLE with x_valid: capture x_in into the active buffer, set idx=0, go to STREAM; the first out_valid SHALL occur on the next cycle (latency 1).
REQ-014 STREAM: each cycle drive out_valid=1 and out_data=active[idx], then idx++.
- Elements SHALL be emitted in order 0..numNeurons-1, back-to-back, with no bubbles.
REQ-015 STREAM after emitting element numNeurons-1: go to GAP with out_valid=0.
REQ-016 GAP SHALL last exactly gapCycles cycles with out_valid=0, then:
- if the pending slot is full, move pending to active and go to STREAM;
- otherwise go to IDLE.
REQ-017 x_valid in STREAM or GAP with the pending slot empty: capture x_in into the pending slot.
REQ-018 x_valid with the pending slot full, and the slot not being drained that cycle:
- drop the new frame;
- set overrun=1 until reset.
REQ-019 x_valid in the same cycle as pending→active transfer: the new frame SHALL enter pending; overrun SHALL NOT be set.
REQ-020 Stored data SHALL be unchanged from capture to emission; no arithmetic is performed on elements.
REQ-021 out_data SHALL hold its last value while out_valid=0.
REQ-022 idx width SHALL be $clog2(numNeurons); idx wrap SHALL never occur, since the state leaves STREAM at numNeurons-1.

Reset
REQ-023 While rst=1 on a clock edge:
- out_data=0, out_valid=0, busy=0, overrun=0;
- state=IDLE, idx=0, pending slot empty.
REQ-024 rst mid-STREAM SHALL abort the frame; out_valid SHALL be 0 on the cycle after the reset edge.
REQ-025 x_valid coincident with rst SHALL be ignored.

Configuration
REQ-026 With macro SER_LAST_EN defined, the block SHALL add output out_last (1 bit).
- out_last is high exactly when out_valid=1 and element numNeurons-1 is emitted.
- out_last resets to 0.
REQ-027 Without SER_LAST_EN, out_last SHALL not exist, and behaviour SHALL be otherwise identical.

Structure
REQ-028 The state encodings and the default dataWidth/numNeurons constants SHALL live in the shared package nn_stream_pkg.
REQ-029 Active and pending frame storage SHALL be a single sub-module, frame_buffer (two slots: load, swap, and indexed read).

Verification (numNeurons=4, dataWidth=16, gapCycles=2)
REQ-030 Single frame x_in={0x0004,0x0003,0x0002,0x0001}, x_valid at t0 -> out_valid t1..t4 with data 0x0001,0x0002,0x0003,0x0004; out_valid=0 at t5, t6; busy=0 from t7.
REQ-031 Second frame at t2 -> its first element at t7, immediately after the 2-cycle gap; overrun=0.
REQ-032 Frames at t0, t2, t3 -> third frame dropped, overrun=1 from t4 and held, second frame emitted intact.
REQ-033 Frame at t0, new frame at the t6 transfer edge (pending full at t2) -> both later frames emitted; overrun=0.
REQ-034 rst at t2 during a stream -> out_valid=0 from t3; a frame at t5 streams from t6 starting with element 0.
REQ-035 With SER_LAST_EN defined, in the REQ-030 run -> out_last=1 only at t4.
